crossing_scheduler: RTL and testbench

//  Sequencer for the river-crossing game. Accepts debounced button requests, queues them and

---
 rtl/crossing_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_crossing_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossing_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : crossing_scheduler
// Purpose  : River-crossing game sequencer. It queues button requests, checks
//            that each is legal, launches crossings on the animation engine
//            and judges the result. CROSSING_UNDO_EN adds one level of undo.
// Revision : 1.0 - initial release
// ============================================================================
module crossing_scheduler #(
    parameter int QDEPTH        = 4,
    parameter int TIMEOUT_STEPS = 24,
    parameter int MOVE_W        = 8
) (
    input  logic              clk_1kHz,
    input  logic              rst,
    input  logic              step_tick,
    input  logic [3:0]        req,
    input  logic              restart,
    input  logic              undo,
    output logic              anim_start,
    output logic [1:0]        anim_who,
    output logic              anim_dir,
    input  logic              anim_done,
    output logic [3:0]        pos,
    output logic              busy,
    output logic [1:0]        game_state,
    output logic [MOVE_W-1:0] move_cnt,
    output logic              q_full,
    output logic              drop,
    output logic              reject,
    output logic              timeout
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_STEPS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_JUDGE  = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    localparam logic [1:0] G_LOSE   = 2'd0;
    localparam logic [1:0] G_WIN    = 2'd1;
    localparam logic [1:0] G_PLAY   = 2'd2;
    localparam logic [1:0] WHO_NONE = 2'd3;

    logic [2:0]        r_state;
    logic [1:0]        r_fifo [QDEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [1:0]        r_who;
    logic [3:0]        r_pos;
    logic [1:0]        r_game;
    logic [MOVE_W-1:0] r_moves;
    logic [TW-1:0]     r_tcnt;
    logic              r_start;
    logic              r_drop;
    logic              r_reject;
    logic              r_timeout;

    logic              w_has_req;
    logic              w_multi;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_undo_go;
    logic              w_legal;
    logic              w_win;
    logic              w_lose;
    logic [1:0]        w_req_who;
    logic [3:0]        w_mask;
    logic [3:0]        w_new_pos;

    // Priority cat > dog > mouse > canoe-alone; bit 0 alone maps to WHO_NONE.
    always_comb begin
        w_req_who = WHO_NONE;
        if (req[3])
            w_req_who = 2'd0;
        else if (req[2])
            w_req_who = 2'd1;
        else if (req[1])
            w_req_who = 2'd2;
    end

    assign w_has_req = |req;
    assign w_multi   = (req & (req - 4'd1)) != 4'd0;
    assign w_full    = (r_count == (AW+1)'(QDEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = w_has_req && !w_full && (r_game == G_PLAY);

    // Passenger bit within {cat,dog,mouse,canoe}; the canoe always travels.
    assign w_mask    = (r_who == WHO_NONE) ? 4'b0000 : (4'b1000 >> r_who);
    assign w_legal   = (r_who == WHO_NONE) || ((|(r_pos & w_mask)) == r_pos[0]);
    assign w_new_pos = r_pos ^ (w_mask | 4'b0001);
    assign w_win     = &w_new_pos[3:1];
    assign w_lose    = ((w_new_pos[3] == w_new_pos[2]) && (w_new_pos[3] != w_new_pos[0])) ||
                       ((w_new_pos[3] == w_new_pos[1]) && (w_new_pos[3] != w_new_pos[0]));

`ifdef CROSSING_UNDO_EN
    logic [3:0]        r_snap_pos;
    logic [MOVE_W-1:0] r_snap_moves;
    logic              r_snap_valid;

    assign w_undo_go = undo && !restart && (r_state == S_IDLE) && r_snap_valid &&
                       (r_game == G_PLAY);

    always_ff @(posedge clk_1kHz) begin
        if (rst || restart) begin
            r_snap_pos   <= '0;
            r_snap_moves <= '0;
            r_snap_valid <= 1'b0;
        end else if (r_state == S_JUDGE) begin
            r_snap_pos   <= r_pos;
            r_snap_moves <= r_moves;
            r_snap_valid <= 1'b1;
        end else if (w_undo_go) begin
            r_snap_valid <= 1'b0;
        end
    end
`else
    logic w_unused_undo;
    assign w_unused_undo = undo;
    assign w_undo_go     = 1'b0;
`endif

    assign w_pop   = (r_state == S_IDLE) && !w_empty && !w_undo_go;
    assign w_flush = w_undo_go || ((r_state == S_JUDGE) && (w_win || w_lose));

    always_ff @(posedge clk_1kHz) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= w_req_who;
    end

    always_ff @(posedge clk_1kHz) begin
        if (rst || restart || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk_1kHz) begin
        if (rst || restart)
            r_drop <= 1'b0;
        else
            r_drop <= w_has_req && (w_multi || w_full || (r_game != G_PLAY));
    end

    always_ff @(posedge clk_1kHz) begin
        if (rst || restart) begin
            r_state   <= S_IDLE;
            r_who     <= WHO_NONE;
            r_pos     <= '0;
            r_game    <= G_PLAY;
            r_moves   <= '0;
            r_tcnt    <= '0;
            r_start   <= 1'b0;
            r_reject  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_start  <= 1'b0;
            r_reject <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_undo_go) begin
`ifdef CROSSING_UNDO_EN
                        r_pos   <= r_snap_pos;
                        r_moves <= r_snap_moves;
`endif
                    end else if (w_pop) begin
                        r_who   <= r_fifo[r_rd_ptr];
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_legal) begin
                        r_state <= S_LAUNCH;
                    end else begin
                        r_reject <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    r_start <= 1'b1;
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (anim_done) begin
                        r_state <= S_JUDGE;
                    end else if (step_tick) begin
                        if (r_tcnt == TW'(TIMEOUT_STEPS - 1)) begin
                            r_timeout <= 1'b1;
                            r_state   <= S_JUDGE;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_JUDGE: begin
                    r_pos <= w_new_pos;
                    if (r_moves != '1)
                        r_moves <= r_moves + 1'b1;
                    if (w_win) begin
                        r_game  <= G_WIN;
                        r_state <= S_OVER;
                    end else if (w_lose) begin
                        r_game  <= G_LOSE;
                        r_state <= S_OVER;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OVER: begin
                    r_state <= S_OVER;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign anim_start = r_start;
    assign anim_who   = r_who;
    assign anim_dir   = r_pos[0];
    assign pos        = r_pos;
    assign busy       = (r_state != S_IDLE) && (r_state != S_OVER);
    assign game_state = r_game;
    assign move_cnt   = r_moves;
    assign q_full     = w_full;
    assign drop       = r_drop;
    assign reject     = r_reject;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_crossing_scheduler.sv
`default_nettype none
// Bench for crossing_scheduler: a game-rule model predicts launches and the
// settled board; directed scenarios add literal checks on key results.
`timescale 1ns/1ps
module tb_crossing_scheduler;

    localparam int QDEPTH        = 4;
    localparam int TIMEOUT_STEPS = 24;
    localparam int MOVE_W        = 8;

    logic              clk_1kHz = 1'b0;
    logic              rst;
    logic              step_tick;
    logic [3:0]        req;
    logic              restart;
    logic              undo;
    logic              anim_start;
    logic [1:0]        anim_who;
    logic              anim_dir;
    logic              anim_done;
    logic [3:0]        pos;
    logic              busy;
    logic [1:0]        game_state;
    logic [MOVE_W-1:0] move_cnt;
    logic              q_full;
    logic              drop;
    logic              reject;
    logic              timeout;

    crossing_scheduler #(
        .QDEPTH        (QDEPTH),
        .TIMEOUT_STEPS (TIMEOUT_STEPS),
        .MOVE_W        (MOVE_W)
    ) dut (
        .clk_1kHz   (clk_1kHz),
        .rst        (rst),
        .step_tick  (step_tick),
        .req        (req),
        .restart    (restart),
        .undo       (undo),
        .anim_start (anim_start),
        .anim_who   (anim_who),
        .anim_dir   (anim_dir),
        .anim_done  (anim_done),
        .pos        (pos),
        .busy       (busy),
        .game_state (game_state),
        .move_cnt   (move_cnt),
        .q_full     (q_full),
        .drop       (drop),
        .reject     (reject),
        .timeout    (timeout)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    int n_vec  = 0;
    int n_fail = 0;

    // Game model: one bank bit per item plus the outcome of the game so far.
    logic       m_cat, m_dog, m_mouse, m_canoe, m_timeout;
    logic [1:0] m_game;
    int         m_moves;
    logic       chk_en = 1'b0;
    logic [2:0] exp_q[$];
    logic [2:0] e_launch;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_pos();
        return {m_cat, m_dog, m_mouse, m_canoe};
    endfunction

    function automatic logic m_legal(input logic [1:0] who);
        case (who)
            2'd0:    return m_cat == m_canoe;
            2'd1:    return m_dog == m_canoe;
            2'd2:    return m_mouse == m_canoe;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] who_vec(input logic [1:0] who);
        case (who)
            2'd0:    return 4'b1000;
            2'd1:    return 4'b0100;
            2'd2:    return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic m_reset();
        m_cat = 0; m_dog = 0; m_mouse = 0; m_canoe = 0;
        m_timeout = 0; m_game = 2'd2; m_moves = 0;
        exp_q.delete();
    endtask

    task automatic m_apply(input logic [1:0] who);
        m_canoe = ~m_canoe;
        if (who == 2'd0) m_cat   = ~m_cat;
        if (who == 2'd1) m_dog   = ~m_dog;
        if (who == 2'd2) m_mouse = ~m_mouse;
        if (m_moves < 255) m_moves++;
        if (m_cat && m_dog && m_mouse)
            m_game = 2'd1;
        else if ((m_cat == m_dog && m_cat != m_canoe) || (m_cat == m_mouse && m_cat != m_canoe))
            m_game = 2'd0;
    endtask

    always @(negedge clk_1kHz) begin
        if (chk_en) begin
            if (anim_start) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_launch", {31'd0, anim_start}, 32'd0);
                end else begin
                    e_launch = exp_q.pop_front();
                    check("launch_who_dir", {29'd0, anim_who, anim_dir}, {29'd0, e_launch});
                end
            end
            if (!busy) begin
                check("pos", {28'd0, pos}, {28'd0, m_pos()});
                check("game_state", {30'd0, game_state}, {30'd0, m_game});
                check("move_cnt", {24'd0, move_cnt}, 32'(m_moves));
                check("timeout", {31'd0, timeout}, {31'd0, m_timeout});
            end
        end
    end

    task automatic tick();
        @(posedge clk_1kHz);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        m_reset();
    endtask

    task automatic launch(input logic [3:0] vec, input logic [1:0] who, input int exp_lat,
                          input logic exp_drop);
        int n;
        exp_q.push_back({who, m_canoe});
        req = vec;
        tick();
        req = 4'd0;
        check("capture_drop", {31'd0, drop}, {31'd0, exp_drop});
        n = 1;
        while (!anim_start && n < 12) begin
            tick();
            n++;
        end
        check("launch_seen", {31'd0, anim_start}, 32'd1);
        if (exp_lat > 0)
            check("launch_latency", n, exp_lat);
    endtask

    task automatic finish_move(input logic [1:0] who);
        int n;
        repeat (2) tick();
        anim_done = 1'b1;
        m_apply(who);
        tick();
        anim_done = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        check("judge_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic try_reject(input logic [3:0] vec);
        int hi;
        hi = 0;
        req = vec;
        tick();
        req = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (reject) hi++;
            tick();
        end
        check("reject_cycles", hi, 1);
    endtask

    logic [1:0] solution [7] = '{2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; step_tick = 1'b0; req = 4'd0; restart = 1'b0;
        undo = 1'b0; anim_done = 1'b0;
        m_reset();
        repeat (3) tick();
        check("rst_pos", {28'd0, pos}, 32'd0);
        check("rst_game", {30'd0, game_state}, 32'd2);
        check("rst_moves", {24'd0, move_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_qfull", {31'd0, q_full}, 32'd0);
        check("rst_pulses", {28'd0, anim_start, drop, reject, timeout}, 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Cat crosses from reset; then an ignored stray done and an illegal dog.
        launch(4'b1000, 2'd0, 4, 1'b0);
        finish_move(2'd0);
        check("cat_pos", {28'd0, pos}, 32'h9);
        check("cat_moves", {24'd0, move_cnt}, 32'd1);
        anim_done = 1'b1; tick(); anim_done = 1'b0;
        repeat (3) tick();
        try_reject(4'b0100);
        check("reject_pos", {28'd0, pos}, 32'h9);

        // Dog alone from reset loses immediately; OVER drops requests.
        do_restart();
        launch(4'b0100, 2'd1, 4, 1'b0);
        finish_move(2'd1);
        check("lose_pos", {28'd0, pos}, 32'h5);
        check("lose_state", {30'd0, game_state}, 32'd0);
        req = 4'b1000; tick(); req = 4'd0;
        check("over_drop", {31'd0, drop}, 32'd1);
        repeat (6) tick();

        // Simultaneous requests keep only the cat.
        do_restart();
        launch(4'b1110, 2'd0, 4, 1'b1);
        finish_move(2'd0);
        repeat (6) tick();

        // Fill the queue while a crossing is outstanding.
        do_restart();
        launch(4'b1000, 2'd0, 4, 1'b0);
        for (int i = 0; i <= QDEPTH; i++) begin
            req = 4'b0001;
            tick();
            check("fill_drop", {31'd0, drop}, {31'd0, (i == QDEPTH)});
        end
        req = 4'd0;
        tick();
        check("fill_qfull", {31'd0, q_full}, 32'd1);
        do_restart();
        check("flush_qfull", {31'd0, q_full}, 32'd0);
        repeat (8) tick();

        // Withhold anim_done: the 24th step tick forces completion.
        launch(4'b1000, 2'd0, 4, 1'b0);
        for (int i = 0; i < TIMEOUT_STEPS; i++) begin
            step_tick = 1'b1;
            if (i == TIMEOUT_STEPS - 1) begin
                m_apply(2'd0);
                m_timeout = 1'b1;
            end
            tick();
            step_tick = 1'b0;
            if (i == TIMEOUT_STEPS - 2) begin
                check("pre_timeout_busy", {31'd0, busy}, 32'd1);
                check("pre_timeout_flag", {31'd0, timeout}, 32'd0);
            end
            tick();
        end
        repeat (3) tick();
        check("timeout_flag", {31'd0, timeout}, 32'd1);
        check("timeout_pos", {28'd0, pos}, 32'h9);
        do_restart();
        tick();
        check("restart_timeout", {31'd0, timeout}, 32'd0);
        check("restart_pos", {28'd0, pos}, 32'd0);

        // Seven-move solution wins; then drops and a restart that eats a request.
        for (int k = 0; k < 7; k++) begin
            launch(who_vec(solution[k]), solution[k], 4, 1'b0);
            finish_move(solution[k]);
        end
        check("win_pos", {28'd0, pos}, 32'hF);
        check("win_state", {30'd0, game_state}, 32'd1);
        check("win_moves", {24'd0, move_cnt}, 32'd7);
        req = 4'b0010; tick(); req = 4'd0;
        check("win_drop", {31'd0, drop}, 32'd1);
        repeat (4) tick();
        restart = 1'b1; req = 4'b1000;
        tick();
        restart = 1'b0; req = 4'd0;
        m_reset();
        check("restart_req_drop", {31'd0, drop}, 32'd0);
        repeat (8) tick();
        check("restart_req_busy", {31'd0, busy}, 32'd0);
        check("restart_req_moves", {24'd0, move_cnt}, 32'd0);
        check("leftover_launches", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
